// File: rtl/fetch_pkg.sv
// Shared constants for the decoupled fetch unit: PC_src encodings, NOP and reset defaults.
package fetch_pkg;

  localparam int          WORDLENGTH = 32;
  localparam logic [31:0] RESET_PC   = 32'h0;
  localparam logic [31:0] NOP_INSTR  = 32'h0;

  typedef enum logic [1:0] {
    PC_SRC_SEQ    = 2'b00,
    PC_SRC_BRANCH = 2'b01,
    PC_SRC_JUMP   = 2'b10,
    PC_SRC_RSVD   = 2'b11
  } pc_src_e;

  // Encoding 11 is deliberately treated as sequential.
  function automatic logic is_redirect(input logic [1:0] pc_src);
    return (pc_src == PC_SRC_BRANCH) || (pc_src == PC_SRC_JUMP);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Prefetch FIFO holding {instr, pc_plus4}; flush clears it in one cycle.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PW    = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   i_flush,
  input  logic                   i_push,
  input  logic [PW-1:0]          i_push_data,
  input  logic                   i_pop,
  output logic [PW-1:0]          o_head,
  output logic                   o_valid,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);

  logic [PW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_pop  = i_pop && (r_count != '0);
  // A push into a full queue is legal only when the head leaves in the same cycle.
  assign w_push = i_push && ((r_count != (AW+1)'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_data;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_valid = (r_count != '0);
  assign o_count = r_count;

endmodule

// File: rtl/fetch_unit.sv
// Decoupled instruction fetch: credit-limited requests, in-order responses, prefetch queue to ID.
// Define FETCH_PERF_CNT_EN to add saturating perf counters (perf_fetched/redirects/empty_cycles).
module fetch_unit #(
  parameter int                    WORDLENGTH  = fetch_pkg::WORDLENGTH,
  parameter int                    QUEUE_DEPTH = 4,
  parameter logic [WORDLENGTH-1:0] RESET_PC    = WORDLENGTH'(fetch_pkg::RESET_PC)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall,
  input  logic [1:0]            PC_src,
  input  logic [WORDLENGTH-1:0] branch_address,
  input  logic [WORDLENGTH-1:0] jump_address,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [WORDLENGTH-1:0] imem_req_addr,
  input  logic                  imem_resp_valid,
  input  logic [WORDLENGTH-1:0] imem_resp_data,
  output logic [WORDLENGTH-1:0] instruction,
  output logic [WORDLENGTH-1:0] PC_plus4,
  output logic                  if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]           perf_fetched,
  output logic [31:0]           perf_redirects,
  output logic [31:0]           perf_empty_cycles
`endif
);

  import fetch_pkg::*;

  localparam int CW = $clog2(QUEUE_DEPTH) + 1;

  logic [WORDLENGTH-1:0]   r_fetch_pc;
  logic [WORDLENGTH-1:0]   r_ret_pc;
  logic [CW-1:0]           r_outstanding;
  logic [CW-1:0]           r_drop_cnt;

  logic                    w_redirect;
  logic [WORDLENGTH-1:0]   w_target;
  logic                    w_credit;
  logic                    w_issue;
  logic                    w_resp_acc;
  logic                    w_drop;
  logic                    w_push;
  logic                    w_pop;
  logic [2*WORDLENGTH-1:0] w_head;
  logic                    w_q_valid;
  logic [CW-1:0]           w_q_count;

  // Handshakes: a request transfers when imem_req_valid && imem_req_ready at a rising edge;
  // a response transfers whenever imem_resp_valid is high (never back-pressured);
  // ID consumes the head when if_valid && !stall, except in a redirect cycle.
  assign w_redirect = is_redirect(PC_src);
  assign w_target   = (PC_src == PC_SRC_JUMP) ? jump_address : branch_address;
  assign w_credit   = ({1'b0, w_q_count} + {1'b0, r_outstanding}) < (CW+1)'(QUEUE_DEPTH);

  assign imem_req_valid = !reset && !w_redirect && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_issue        = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. stragglers from before a reset) are ignored.
  assign w_resp_acc = imem_resp_valid && (r_outstanding != '0);
  assign w_drop     = w_resp_acc && (r_drop_cnt != '0);
  assign w_push     = w_resp_acc && !w_drop && !w_redirect;
  assign w_pop      = w_q_valid && !stall && !w_redirect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fetch_pc    <= RESET_PC;
      r_ret_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_resp_acc);
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_ret_pc   <= w_target;
        r_drop_cnt <= r_outstanding - CW'(w_resp_acc);
      end else begin
        if (w_issue) r_fetch_pc <= r_fetch_pc + WORDLENGTH'(4);
        // r_ret_pc tracks the fetch address of the next non-stale response.
        if (w_push)  r_ret_pc   <= r_ret_pc + WORDLENGTH'(4);
        if (w_drop)  r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .PW    (2*WORDLENGTH)
  ) u_queue (
    .clk         (clk),
    .reset       (reset),
    .i_flush     (w_redirect),
    .i_push      (w_push),
    .i_push_data ({imem_resp_data, r_ret_pc + WORDLENGTH'(4)}),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_valid     (w_q_valid),
    .o_count     (w_q_count)
  );

  assign if_valid    = w_q_valid;
  assign instruction = w_q_valid ? w_head[2*WORDLENGTH-1:WORDLENGTH] : WORDLENGTH'(NOP_INSTR);
  assign PC_plus4    = w_q_valid ? w_head[WORDLENGTH-1:0] : '0;

  a_resp_has_owner: assert property (@(posedge clk) disable iff (reset)
    imem_resp_valid |-> (r_outstanding != '0));

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_redirects;
  logic [31:0] r_perf_empty;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_fetched   <= '0;
      r_perf_redirects <= '0;
      r_perf_empty     <= '0;
    end else begin
      if (w_push && (r_perf_fetched != '1))       r_perf_fetched   <= r_perf_fetched + 32'd1;
      if (w_redirect && (r_perf_redirects != '1)) r_perf_redirects <= r_perf_redirects + 32'd1;
      if (!w_q_valid && (r_perf_empty != '1))     r_perf_empty     <= r_perf_empty + 32'd1;
    end
  end

  assign perf_fetched      = r_perf_fetched;
  assign perf_redirects    = r_perf_redirects;
  assign perf_empty_cycles = r_perf_empty;
`endif

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Parametrised successor to the single-cycle IF stage: a decoupled instruction-fetch unit.
- Owns the PC and issues requests to a variable-latency instruction memory over a ready/valid interface.
- Buffers returned instructions in a QUEUE_DEPTH-entry prefetch queue and presents them to ID with a valid/stall handshake.
- Handles branch/jump redirects by flushing the queue and discarding stale in-flight responses.

Parameters:
- WORDLENGTH, 32, width of PC, addresses and instructions.
- QUEUE_DEPTH, 4, prefetch queue entries (power of two, >=2); also caps requests in flight.
- RESET_PC, 32'h0, PC value after reset.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  ID cannot accept; head entry held.
- PC_src  in  2  00 sequential, 01 branch, 10 jump, 11 treated as 00.
- branch_address  in  WORDLENGTH  redirect target when PC_src=01.
- jump_address  in  WORDLENGTH  redirect target when PC_src=10.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_req_addr  out  WORDLENGTH  byte address of the fetch.
- imem_resp_valid  in  1  in-order response valid; always accepted, no backpressure.
- imem_resp_data  in  WORDLENGTH  returned instruction.
- instruction  out  WORDLENGTH  head instruction; 0 (NOP) when queue empty.
- PC_plus4  out  WORDLENGTH  head entry's fetch address + 4; 0 when empty.
- if_valid  out  1  head entry valid.

Behaviour:
- Reset (clk edge with reset=1):
  - fetch_pc=RESET_PC; queue empty; outstanding=0; drop_cnt=0.
  - if_valid=0, instruction=0, PC_plus4=0, imem_req_valid=0.
- Redirect: PC_src in {01,10} in a cycle is a redirect.
  - Next edge: queue flushed; fetch_pc=target; drop_cnt = outstanding - (imem_resp_valid ? 1 : 0).
  - Any response arriving in the redirect cycle is discarded.
  - imem_req_valid is forced 0 in the redirect cycle.
- Issue:
  - imem_req_valid = !reset_cycle && !redirect && (queue_count + outstanding < QUEUE_DEPTH).
  - imem_req_addr = fetch_pc.
  - On valid&&ready: fetch_pc += 4 (wraps mod 2^WORDLENGTH), outstanding++.
- Response:
  - On imem_resp_valid: outstanding--.
  - If drop_cnt>0: discard and drop_cnt--.
  - Otherwise enqueue {data, addr+4}; the address comes from a per-entry PC FIFO or is reconstructed from a returned-PC counter.
  - Response with outstanding=0: ignored, assertion fires.
- Credit rule guarantees enqueue never overflows, including simultaneous enqueue+pop at full.
- Pop: if_valid && !stall && !redirect.
- Simultaneous enqueue and pop: count unchanged, both take effect.
- Latency: with a 1-cycle memory, request accepted at edge N, response at N+1, if_valid=1 after edge N+2. No bypass path.
- Throughput: 1 instr/cycle sustained when memory latency < QUEUE_DEPTH.
- Redirect during stall: redirect wins; the queue is flushed even though ID is stalled.
- Back-to-back redirects: the second recomputes drop_cnt from the current outstanding; the latest target wins.
- Reset mid-operation: all state returns to reset values; memory responses after reset with outstanding=0 are ignored.

Optional Feature:
- FETCH_PERF_CNT_EN defined: adds three 32-bit saturating outputs, all cleared by reset:
  - perf_fetched: enqueued instructions.
  - perf_redirects: redirect cycles.
  - perf_empty_cycles: cycles with if_valid=0 and reset=0.
- Undefined: no counters and no ports; behaviour otherwise identical.

Decomposition:
- Shared package fetch_pkg: WORDLENGTH, PC_SRC_SEQ/BRANCH/JUMP encodings, NOP_INSTR=0, RESET_PC default.
- One sub-module: fetch_queue, a synchronous FIFO with a flush input, count output and {instr, pc_plus4} payload, instantiated once.

Test Plan:
- Reset, memory always ready, 1-cycle latency, stall=0:
  - first req addr 0x0 on the first cycle after reset.
  - if_valid rises 2 cycles later with PC_plus4=0x4.
  - then PC_plus4 = 0x8, 0xC, … one per cycle.
- stall held 10 cycles:
  - queue fills to 4, outstanding to 0, imem_req_valid=0.
  - outputs hold the same entry; release pops one per cycle with no loss or duplication.
- 3-cycle memory latency, 3 requests in flight, PC_src=01 with branch_address=0x100:
  - the 3 stale responses are dropped.
  - next if_valid entry has PC_plus4=0x104.
- Redirect coinciding with imem_resp_valid and stall=1:
  - response discarded, queue flushed, drop_cnt = outstanding-1.
  - fetch resumes at the target.
- Reset asserted with 2 requests outstanding:
  - after reset, late responses ignored (assertion only), fetch restarts at RESET_PC.
- With FETCH_PERF_CNT_EN: run 20 cycles with 1 redirect:
  - perf_redirects=1.
  - perf_fetched matches enqueued count.
  - perf_empty_cycles counts cycles with if_valid=0 after reset.
